// File: rtl/taillight_seq_ctrl_if.sv
// Switch/lamp bundle for the rear-lamp controller.
// There is no valid/ready handshake here: the switch inputs are
// level-sensitive and sampled on every clock edge, and all outputs are
// registered levels. The state field carries the one-hot FSM register so
// that a checker can observe it.
interface taillight_seq_ctrl_if #(
  parameter int LAMPS = 3
);
  logic                 left_sw;
  logic                 right_sw;
  logic                 haz_sw;
  logic                 brake_n;
  logic                 L;
  logic                 H;
  logic                 R;
  logic [2*LAMPS-1:0]   lights;
  logic [3:0]           state;

  modport master (
    output left_sw, right_sw, haz_sw, brake_n,
    input  L, H, R, lights, state
  );

  modport slave (
    input  left_sw, right_sw, haz_sw, brake_n,
    output L, H, R, lights, state
  );
endinterface

// File: rtl/taillight_seq_ctrl.sv
// Rear-lamp controller: turn/hazard FSM with an internal prescaler and
// step sequencer producing sequential-sweep or flash animations, with a
// brake overlay on the non-animated side. All outputs are registered and
// computed from next-state/next-step so a switch change shows in one edge.
module taillight_seq_ctrl #(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 12_500_000,
  parameter int HAZ_MODE = 0
) (
  input logic                clk,
  input logic                rst,
  taillight_seq_ctrl_if.slave bus
);
  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_LEFT  = 4'b0010;
  localparam logic [3:0] ST_RIGHT = 4'b0100;
  localparam logic [3:0] ST_HAZ   = 4'b1000;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(LAMPS + 1);

  logic [3:0]         state, state_nxt;
  logic [PW-1:0]      presc, presc_nxt;
  logic [SW-1:0]      step, step_nxt, step_max;
  logic               restart, tick, flash;
  logic [LAMPS-1:0]   anim_l, anim_r;
  logic [2*LAMPS-1:0] lights_nxt;

  assign bus.state = state;

  // Next-state decode (hazard wins, conflicting turns mean idle) and the
  // prescaler/step advance; a state change restarts the animation.
  always_comb begin
    state_nxt = ST_IDLE;
    if (bus.haz_sw)                       state_nxt = ST_HAZ;
    else if (bus.left_sw && !bus.right_sw) state_nxt = ST_LEFT;
    else if (bus.right_sw && !bus.left_sw) state_nxt = ST_RIGHT;

    restart  = (state_nxt != state);
    tick     = (presc == PW'(TICK_DIV - 1));
    flash    = (HAZ_MODE != 0) && (state_nxt == ST_HAZ);
    step_max = flash ? SW'(1) : SW'(LAMPS);

    presc_nxt = presc + PW'(1);
    if (restart || tick) presc_nxt = '0;

    step_nxt = step;
    if (restart)               step_nxt = '0;
    else if (tick)             step_nxt = (step == step_max) ? '0 : step + SW'(1);
  end

  // Lamp pattern for the next step: inner lamps fill first on each side.
  always_comb begin
    anim_l = '0;
    anim_r = '0;
    for (int i = 0; i < LAMPS; i++) begin
      if (flash) begin
        anim_l[i]           = (step_nxt == '0);
        anim_r[LAMPS-1-i]   = (step_nxt == '0);
      end else begin
        anim_l[i]           = (step_nxt < SW'(LAMPS)) && (SW'(i) <= step_nxt);
        anim_r[LAMPS-1-i]   = (step_nxt < SW'(LAMPS)) && (SW'(i) <= step_nxt);
      end
    end

    lights_nxt = '0;
    case (state_nxt)
      ST_IDLE:  lights_nxt = bus.brake_n ? '0 : '1;
      ST_LEFT:  lights_nxt = {anim_l, (bus.brake_n ? {LAMPS{1'b0}} : {LAMPS{1'b1}})};
      ST_RIGHT: lights_nxt = {(bus.brake_n ? {LAMPS{1'b0}} : {LAMPS{1'b1}}), anim_r};
      ST_HAZ:   lights_nxt = {anim_l, anim_r};
      default:  lights_nxt = '0;
    endcase
  end

  // State, sequencer and registered outputs, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      presc      <= '0;
      step       <= '0;
      bus.lights <= '0;
      bus.L      <= 1'b0;
      bus.H      <= 1'b0;
      bus.R      <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      step       <= step_nxt;
      bus.lights <= lights_nxt;
      bus.L      <= (state_nxt == ST_LEFT);
      bus.H      <= (state_nxt == ST_HAZ);
      bus.R      <= (state_nxt == ST_RIGHT);
    end
  end
endmodule

// File: tb/tb_taillight_seq_ctrl.sv
// Bench for taillight_seq_ctrl: three instances (sweep hazard, flash
// hazard, single-lamp fast tick) share one stimulus. A time-since-entry
// model predicts every output each cycle, and directed literal checks pin
// the model to hand-computed patterns.
module tb_taillight_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic left_sw = 1'b0, right_sw = 1'b0, haz_sw = 1'b0, brake_n = 1'b1;

  int n_vec = 0;
  int n_bad = 0;

  // clock/reset block
  always #5 clk = ~clk;

  taillight_seq_ctrl_if #(.LAMPS(3)) if0 ();
  taillight_seq_ctrl_if #(.LAMPS(3)) if1 ();
  taillight_seq_ctrl_if #(.LAMPS(1)) if2 ();

  assign if0.left_sw = left_sw;  assign if0.right_sw = right_sw;
  assign if0.haz_sw  = haz_sw;   assign if0.brake_n  = brake_n;
  assign if1.left_sw = left_sw;  assign if1.right_sw = right_sw;
  assign if1.haz_sw  = haz_sw;   assign if1.brake_n  = brake_n;
  assign if2.left_sw = left_sw;  assign if2.right_sw = right_sw;
  assign if2.haz_sw  = haz_sw;   assign if2.brake_n  = brake_n;

  taillight_seq_ctrl #(.LAMPS(3), .TICK_DIV(4), .HAZ_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  taillight_seq_ctrl #(.LAMPS(3), .TICK_DIV(4), .HAZ_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  taillight_seq_ctrl #(.LAMPS(1), .TICK_DIV(1), .HAZ_MODE(0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  // ---------------- model ----------------
  // mode: 0 idle, 1 left, 2 right, 3 hazard; el = cycles since mode entry
  int         md [3];
  int         el [3];
  logic [5:0] exp_li  [3];
  logic [2:0] exp_lhr [3];
  logic       primed = 1'b0;

  function automatic logic [5:0] model_lights(int lamps, int td, int hm, int m, int e, logic bn);
    int full, nsteps, s, a_l, a_r, v;
    full   = (1 << lamps) - 1;
    nsteps = (m == 3 && hm == 1) ? 2 : lamps + 1;
    s      = (e / td) % nsteps;
    if (m == 3 && hm == 1) begin
      a_l = (s == 0) ? full : 0;
      a_r = a_l;
    end else if (s < lamps) begin
      a_l = (1 << (s + 1)) - 1;
      a_r = a_l << (lamps - s - 1);
    end else begin
      a_l = 0;
      a_r = 0;
    end
    case (m)
      0:       v = bn ? 0 : ((full << lamps) | full);
      1:       v = (a_l << lamps) | (bn ? 0 : full);
      2:       v = (bn ? 0 : (full << lamps)) | a_r;
      default: v = (a_l << lamps) | a_r;
    endcase
    return 6'(v);
  endfunction

  function automatic logic [2:0] model_lhr(int m);
    case (m)
      1:       return 3'b100;
      2:       return 3'b001;
      3:       return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  always @(posedge clk) begin
    int nm, lamps, td, hm;
    nm = haz_sw ? 3 : (left_sw && !right_sw) ? 1 : (right_sw && !left_sw) ? 2 : 0;
    for (int d = 0; d < 3; d++) begin
      lamps = (d == 2) ? 1 : 3;
      td    = (d == 2) ? 1 : 4;
      hm    = (d == 1) ? 1 : 0;
      if (rst) begin
        md[d] = 0;
        el[d] = 0;
        exp_li[d]  = '0;
        exp_lhr[d] = '0;
      end else begin
        if (nm != md[d]) begin
          md[d] = nm;
          el[d] = 0;
        end else begin
          el[d] = el[d] + 1;
        end
        exp_li[d]  = model_lights(lamps, td, hm, md[d], el[d], brake_n);
        exp_lhr[d] = model_lhr(md[d]);
      end
    end
    primed = 1'b1;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (primed) begin
      chk("dut0_lights", if0.lights, exp_li[0]);
      chk("dut0_lhr", {3'b0, if0.L, if0.H, if0.R}, {3'b0, exp_lhr[0]});
      chk("dut1_lights", if1.lights, exp_li[1]);
      chk("dut1_lhr", {3'b0, if1.L, if1.H, if1.R}, {3'b0, exp_lhr[1]});
      chk("dut2_lights", {4'b0, if2.lights}, exp_li[2]);
      chk("dut2_lhr", {3'b0, if2.L, if2.H, if2.R}, {3'b0, exp_lhr[2]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic l, input logic r, input logic h, input logic bn);
    left_sw = l; right_sw = r; haz_sw = h; brake_n = bn;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    drive(0, 0, 0, 1);
    cyc(3);
    chk("reset_lights", if0.lights, 6'b000000);
    chk("reset_lhr", {3'b0, if0.L, if0.H, if0.R}, 6'b000000);

    // left sweep
    rst = 1'b0;
    drive(1, 0, 0, 1);
    cyc(1);  chk("left_s0", if0.lights, 6'b001000);
    chk("left_lhr", {3'b0, if0.L, if0.H, if0.R}, 6'b000100);
    cyc(3);  chk("left_s0_hold", if0.lights, 6'b001000);
    cyc(1);  chk("left_s1", if0.lights, 6'b011000);
    cyc(4);  chk("left_s2", if0.lights, 6'b111000);
    cyc(4);  chk("left_s3", if0.lights, 6'b000000);
    cyc(4);  chk("left_wrap", if0.lights, 6'b001000);
    cyc(8);  chk("left_s2_again", if0.lights, 6'b111000);

    // left -> right at step 2 restarts the sweep
    drive(0, 1, 0, 1);
    cyc(1);  chk("l2r_s0", if0.lights, 6'b000100);
    cyc(3);  chk("l2r_s0_hold", if0.lights, 6'b000100);
    cyc(1);  chk("l2r_s1", if0.lights, 6'b000110);
    drive(1, 1, 0, 1);
    cyc(1);  chk("both_idle", if0.lights, 6'b000000);
    chk("both_lhr", {3'b0, if0.L, if0.H, if0.R}, 6'b000000);

    // right with brake
    drive(0, 0, 0, 0);
    cyc(1);  chk("idle_brake", if0.lights, 6'b111111);
    drive(0, 1, 0, 0);
    cyc(1);  chk("rb_s0", if0.lights, 6'b111100);
    cyc(4);  chk("rb_s1", if0.lights, 6'b111110);
    cyc(4);  chk("rb_s2", if0.lights, 6'b111111);
    cyc(4);  chk("rb_s3", if0.lights, 6'b111000);
    cyc(4);  chk("rb_wrap", if0.lights, 6'b111100);
    cyc(1);
    drive(0, 1, 0, 1);
    cyc(1);  chk("brake_release", if0.lights, 6'b000100);

    // hazard, brake ignored
    drive(1, 0, 1, 0);
    cyc(1);  chk("haz_s0", if0.lights, 6'b001100);
    chk("haz_lhr", {3'b0, if0.L, if0.H, if0.R}, 6'b000010);
    chk("flash_on0", if1.lights, 6'b111111);
    cyc(4);  chk("haz_s1", if0.lights, 6'b011110);
    chk("flash_off0", if1.lights, 6'b000000);
    cyc(4);  chk("haz_s2", if0.lights, 6'b111111);
    chk("flash_on1", if1.lights, 6'b111111);
    cyc(4);  chk("haz_s3", if0.lights, 6'b000000);
    chk("flash_off1", if1.lights, 6'b000000);

    // reset mid-sweep
    drive(1, 0, 0, 0);
    cyc(1);  chk("lb_s0", if0.lights, 6'b001111);
    cyc(5);  chk("lb_s1", if0.lights, 6'b011111);
    rst = 1'b1;
    cyc(1);  chk("rst_mid_lights", if0.lights, 6'b000000);
    chk("rst_mid_lhr", {3'b0, if0.L, if0.H, if0.R}, 6'b000000);
    cyc(2);  chk("rst_hold", if0.lights, 6'b000000);
    rst = 1'b0;
    drive(1, 0, 0, 1);
    cyc(1);  chk("post_rst_s0", if0.lights, 6'b001000);
    chk("fast_on0", {4'b0, if2.lights}, 6'b000010);
    cyc(1);  chk("fast_off", {4'b0, if2.lights}, 6'b000000);
    cyc(1);  chk("fast_on1", {4'b0, if2.lights}, 6'b000010);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
